// File: rtl/dma_ctrl.sv
// DMA word-counter controller: decodes instructions and paces an external
// 8-bit word counter through count-down, count-up and free-run modes.
module dma_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] instr,
  input  logic       instr_valid,
  input  logic [7:0] din,
  input  logic       cnt_stb,
  input  logic [7:0] dowc_in,
  output logic       plwc,
  output logic       reswc,
  output logic       enw,
  output logic       incw,
  output logic       decw,
  output logic       wci,
  output logic [7:0] wc_data,
  output logic [1:0] mode,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic       done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] mode_q;
  logic [7:0] word_reg;
  logic       done_q;

  logic       up;
  logic       step;
  logic [7:0] wc_inc;
  logic       term_step;
  logic       term_en;
  logic       wrap3;

  assign up     = mode_q[1] ^ mode_q[0];
  assign step   = (state == RUN) && cnt_stb && !instr_valid;
  assign wc_inc = dowc_in + 8'd1;

  // Terminal tests look at the counter value before this cycle's step.
  assign term_step = ((mode_q == 2'd0) && (dowc_in == 8'd1)) ||
                     ((mode_q == 2'd1) && (wc_inc == word_reg));
  assign term_en   = ((mode_q == 2'd0) && (dowc_in == 8'd0)) ||
                     ((mode_q == 2'd1) && (dowc_in == word_reg) &&
                      (word_reg != 8'd0));
  assign wrap3     = (mode_q == 2'd3) && (dowc_in == 8'd1);

  always_comb begin
    state_nx = state;
    if (instr_valid) begin
      case (instr)
        3'd0, 3'd4, 3'd5, 3'd7: state_nx = IDLE;
        3'd6: if (state == IDLE) state_nx = term_en ? DONE : RUN;
        default: ;
      endcase
    end else if (step && term_step) begin
      state_nx = DONE;
    end
  end

  always_comb begin
    plwc    = 1'b0;
    reswc   = 1'b0;
    enw     = 1'b0;
    incw    = 1'b0;
    decw    = 1'b0;
    wci     = 1'b0;
    wc_data = 8'd0;
    dout    = 8'd0;
    dout_oe = 1'b0;
    if (!rst_n) begin
      reswc = 1'b1;
    end else begin
      wci = (mode_q == 2'd0);
      if (instr_valid) begin
        case (instr)
          3'd1: begin
            dout_oe = 1'b1;
            dout    = {6'b0, mode_q};
          end
          3'd2: begin
            dout_oe = 1'b1;
            dout    = dowc_in;
          end
          3'd3: begin
            dout_oe = 1'b1;
            dout    = word_reg;
          end
          3'd4: begin
            if (up) reswc = 1'b1;
            else begin
              plwc    = 1'b1;
              wc_data = word_reg;
            end
          end
          3'd5: begin
            if (up) reswc = 1'b1;
            else begin
              plwc    = 1'b1;
              wc_data = din;
            end
          end
          default: ;
        endcase
      end else if (step) begin
        enw  = 1'b1;
        incw = up;
        decw = !up;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= 2'd0;
      word_reg <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= (state_nx == DONE) || (step && wrap3);
      if (instr_valid && (instr == 3'd0)) mode_q <= din[1:0];
      if (instr_valid && (instr == 3'd5)) word_reg <= din;
    end
  end

  assign mode = rst_n ? mode_q : 2'd0;
  assign done = rst_n && done_q;
  assign busy = rst_n && (state == RUN);

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 The block SHALL have no parameters; all data paths SHALL be 8 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 instr  in  3  instruction code, sampled when instr_valid=1.
REQ-005 instr_valid  in  1  instruction strobe.
REQ-006 din  in  8  data bus for instructions 0 and 5.
REQ-007 cnt_stb  in  1  one transfer completed; requests one count step.
REQ-008 dowc_in  in  8  current word-counter value, fed back from the downstream counter.
REQ-009 plwc, reswc, enw, incw, decw, wci  out  1 each  word-counter controls (load, clear, enable, up, down, carry-in).
REQ-010 wc_data  out  8  load value for the word counter.
REQ-011 mode  out  2  control register.
REQ-012 dout  out  8  read data; SHALL be 0 when dout_oe=0.
REQ-013 dout_oe  out  1  read data valid.
REQ-014 done  out  1  transfer-complete flag.
REQ-015 busy  out  1  high in state RUN.

Function
REQ-016 Registered state SHALL be mode[1:0], word_reg[7:0] and FSM {IDLE, RUN, DONE}; done SHALL be 1 exactly in DONE, except in mode 3 (REQ-027).
REQ-017 All word-counter control outputs, wc_data, dout and dout_oe SHALL be combinational from the current inputs and registered state, so the counter acts on the same edge.
REQ-018 Modes: 0 = count down to zero and stop; 1 = count up to word_reg; 2 = free-run up; 3 = free-run down with wrap.
REQ-019 wci SHALL be 1 in mode 0 (hold at 0) and 0 in modes 1, 2 and 3.
REQ-020 Instructions, decoded only when instr_valid=1:
- 0 WRCR: mode<=din[1:0]; FSM->IDLE.
- 1 RDCR: dout={6'b0,mode}.
- 2 RDWC: dout=dowc_in.
- 3 RDWR: dout=word_reg.
- 4 REINIT: modes 0/3: plwc=1, wc_data=word_reg; modes 1/2: reswc=1; FSM->IDLE.
- 5 LDWC: word_reg<=din; modes 0/3: plwc=1, wc_data=din; modes 1/2: reswc=1; FSM->IDLE.
- 6 ENABLE: IDLE->RUN, or IDLE->DONE if the terminal condition already holds (REQ-025); no effect in RUN or DONE.
- 7 STOP: RUN/DONE->IDLE.
REQ-021 dout_oe SHALL be 1 only for instructions 1-3 with instr_valid=1; reads SHALL NOT change state.
REQ-022 A count step SHALL occur only when the FSM is in RUN, cnt_stb=1 and instr_valid=0; the step drives enw=1 plus incw (modes 1 and 2) or decw (modes 0 and 3).
REQ-023 When instr_valid=1, cnt_stb SHALL be ignored in that cycle (the instruction wins).
REQ-024 Outside a count step, enw, incw and decw SHALL be 0. wc_data SHALL be 0 unless plwc=1.
REQ-025 Terminal conditions, evaluated on the pre-step dowc_in:
- mode 0: step with dowc_in=1 -> DONE next cycle; ENABLE with dowc_in=0 -> DONE.
- mode 1: step with dowc_in+1 equal to word_reg (mod 256) -> DONE; word_reg=0 means 256 steps (terminates at dowc_in=FF). ENABLE with dowc_in=word_reg and word_reg!=0 -> DONE.
REQ-026 Mode 2 SHALL never terminate; the counter wraps FF->00.
REQ-027 Mode 3: a step with dowc_in=1 SHALL pulse done for exactly one cycle while the FSM stays in RUN; the counter wraps 00->FF.
REQ-028 In DONE, cnt_stb SHALL be ignored; only instructions 0, 4, 5 or 7 leave DONE (to IDLE).

Reset
REQ-029 While rst_n=0: mode=0, word_reg=0, FSM=IDLE, and done, busy, dout_oe and dout =0; reswc=1 and all other counter controls =0.
REQ-030 Reset SHALL override instr_valid and cnt_stb. Reset in RUN SHALL abandon the transfer, with no done pulse.

Verification
REQ-031 Reset, then WRCR din=00, LDWC din=03 -> plwc=1, wc_data=03; ENABLE; 3 cnt_stb -> decw pulses; done=1 after the third step; a 4th stb gives enw=0.
REQ-032 Mode 1, LDWC din=00 -> reswc=1; ENABLE; 256 stb -> done rises only after the stb with dowc_in=FF.
REQ-033 Mode 3, word count 02, run 5 stb -> done pulses exactly once (at dowc_in=1), busy stays 1, and wci=0 throughout.
REQ-034 In RUN, same-cycle instr_valid (RDWC) and cnt_stb -> dout=dowc_in, dout_oe=1, enw=0.
REQ-035 rst_n low for one cycle mid-RUN -> busy=0, mode=0, reswc=1 that cycle, no done; subsequent cnt_stb ignored.
REQ-036 Mode 0, LDWC 00, ENABLE -> immediate DONE; STOP -> IDLE, done=0.
